// File: rtl/pool_unit_arbiter_if.sv
// Requester-side bundle for pool_unit_arbiter.
// Sample handshake toward the arbiter, result strobe back out.
interface pool_unit_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_data;

   modport master (
      output req_valid, req_data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/pool_unit_arbiter.sv
// Round-robin owner of a shared avg_pool_unit: grants one requester a
// whole window, sequences the unit, and returns the pooled result.
module pool_unit_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 32,
   parameter int WIN      = 4,
   parameter int POOL_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   pool_unit_arbiter_if.slave bus,
   output logic              busy,
   output logic [2:0]        gnt_id,
   output logic              pool_rst,
   output logic              pool_en,
   output logic [DATA_W-1:0] pool_ip,
   input  logic [DATA_W-1:0] pool_op
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RESET = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam int CW = $clog2(WIN + 1);
   localparam int LW = $clog2(POOL_LAT + 1);
   localparam logic [CW-1:0] WIN_C  = CW'(WIN);
   localparam logic [CW-1:0] WIN_M1 = CW'(WIN - 1);
   localparam logic [LW-1:0] LAT_M1 = LW'(POOL_LAT - 1);
   localparam logic [2:0]    LAST   = 3'(N_REQ - 1);

   logic [2:0]        state;
   logic [2:0]        rr_ptr;
   logic [2:0]        sel;
   logic              any;
   logic [CW-1:0]     cnt;
   logic [LW-1:0]     wcnt;
   logic [N_REQ-1:0]  gsel;
   logic              gvalid;
   logic [DATA_W-1:0] gdata;
   logic              accept;
   logic [N_REQ-1:0]  rdy;
   logic [N_REQ-1:0]  rsp_v;
   logic [DATA_W-1:0] rsp_d;
   logic [2:0]        nxt_ptr;

   // Smallest wrapped distance from rr_ptr wins.
   always_comb begin
      int best;
      int d;
      best = N_REQ;
      d    = 0;
      sel  = 3'd0;
      for (int k = 0; k < N_REQ; k++) begin
         if (bus.req_valid[k]) begin
            d = k - int'(rr_ptr);
            if (d < 0) d = d + N_REQ;
            if (d < best) begin
               best = d;
               sel  = 3'(k);
            end
         end
      end
   end

   assign any = |bus.req_valid;

   always_comb begin
      gsel   = '0;
      gvalid = 1'b0;
      gdata  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_id == 3'(k)) begin
            gsel[k] = 1'b1;
            gvalid  = bus.req_valid[k];
            gdata   = bus.req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdy = '0;
      if (state == S_FEED && cnt < WIN_C) rdy = gsel;
   end

   assign accept  = gvalid && (state == S_FEED) && (cnt < WIN_C);
   assign nxt_ptr = (gnt_id == LAST) ? 3'd0 : gnt_id + 3'd1;

   assign bus.req_ready = rdy;
   assign bus.rsp_valid = rsp_v;
   assign bus.rsp_data  = rsp_d;
   assign busy          = (state != S_IDLE);
   assign pool_rst      = (state == S_RESET);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         rr_ptr  <= 3'd0;
         gnt_id  <= 3'd0;
         cnt     <= '0;
         wcnt    <= '0;
         rsp_v   <= '0;
         rsp_d   <= '0;
         pool_en <= 1'b0;
         pool_ip <= '0;
      end else begin
         rsp_v   <= '0;
         pool_en <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (any) begin
                  gnt_id <= sel;
                  state  <= S_RESET;
               end
            end
            S_RESET: begin
               cnt   <= '0;
               state <= S_FEED;
            end
            S_FEED: begin
               // A stalled requester keeps the grant; pool_ip holds.
               pool_en <= accept;
               if (accept) begin
                  pool_ip <= gdata;
                  cnt     <= cnt + 1'b1;
                  if (cnt == WIN_M1) begin
                     wcnt  <= '0;
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (wcnt == LAT_M1) state <= S_RESP;
               else                wcnt  <= wcnt + 1'b1;
            end
            S_RESP: begin
               rsp_v  <= gsel;
               rsp_d  <= pool_op;
               rr_ptr <= nxt_ptr;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_unit_arbiter.sv
// Directed bench for pool_unit_arbiter with a behavioural 2x2 average
// unit; a second N_REQ=2, POOL_LAT=5 instance runs alongside.
module tb_pool_unit_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pool_unit_arbiter_if #(.N_REQ(4), .DATA_W(32)) bus ();
   logic        busy;
   logic [2:0]  gnt_id;
   logic        pool_rst;
   logic        pool_en;
   logic [31:0] pool_ip;
   logic [31:0] pool_op;

   pool_unit_arbiter #(.N_REQ(4), .DATA_W(32), .WIN(4), .POOL_LAT(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .gnt_id   (gnt_id),
      .pool_rst (pool_rst),
      .pool_en  (pool_en),
      .pool_ip  (pool_ip),
      .pool_op  (pool_op)
   );

   pool_unit_arbiter_if #(.N_REQ(2), .DATA_W(32)) bus2 ();
   logic        busy2;
   logic [2:0]  gid2;
   logic        prst2;
   logic        pen2;
   logic [31:0] pip2;
   logic [31:0] pop2;
   logic [1:0]  rv2 = 2'b00;

   assign pop2          = 32'd77;
   assign bus2.req_valid = rv2;
   assign bus2.req_data  = '0;

   pool_unit_arbiter #(.N_REQ(2), .DATA_W(32), .WIN(4), .POOL_LAT(5)) dut2 (
      .clk      (clk),
      .rst      (rst2),
      .bus      (bus2),
      .busy     (busy2),
      .gnt_id   (gid2),
      .pool_rst (prst2),
      .pool_en  (pen2),
      .pool_ip  (pip2),
      .pool_op  (pop2)
   );

   // Average unit model: result valid exactly POOL_LAT after last enable.
   logic signed [31:0] acc = '0;
   logic signed [31:0] p0 = '0;
   logic signed [31:0] p1 = '0;
   always @(posedge clk) begin
      if (pool_rst)     acc <= '0;
      else if (pool_en) acc <= acc + $signed(pool_ip);
      p0 <= acc >>> 2;
      p1 <= p0;
   end
   assign pool_op = p1;

   logic [31:0] sv [4][64];
   int          nsamp [4] = '{default: 0};
   int          ptr [4] = '{default: 0};
   logic [3:0]  gap = '0;
   logic [3:0]  rv;
   logic [127:0] rd;

   always_comb begin
      rv = '0;
      rd = '0;
      for (int i = 0; i < 4; i++) begin
         rv[i] = (ptr[i] < nsamp[i]) && !gap[i];
         rd[i*32 +: 32] = sv[i][ptr[i][5:0]];
      end
   end
   assign bus.req_valid = rv;
   assign bus.req_data  = rd;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (bus.req_valid[i] && bus.req_ready[i]) ptr[i] <= ptr[i] + 1;
   end

   int ridx [64];
   int rdat [64];
   int rcyc [64];
   int gid [64];
   int gcyc [64];
   int ecnt [64] = '{default: 0};
   int efirst [64];
   int elast [64];
   int rn = 0;
   int gn = 0;
   int viol = 0;

   function automatic int enc(input logic [3:0] v);
      enc = 0;
      for (int k = 0; k < 4; k++) if (v[k]) enc = k;
   endfunction

   always @(negedge clk) begin
      if (|bus.rsp_valid) begin
         ridx[rn] <= enc(bus.rsp_valid);
         rdat[rn] <= bus.rsp_data;
         rcyc[rn] <= cyc;
         rn <= rn + 1;
         if ($countones(bus.rsp_valid) != 1) viol <= viol + 1;
      end
      if (pool_rst) begin
         gid[gn]  <= int'(gnt_id);
         gcyc[gn] <= cyc;
         gn <= gn + 1;
      end
      if (pool_en && gn > 0) begin
         if (ecnt[gn-1] == 0) efirst[gn-1] <= cyc;
         elast[gn-1] <= cyc;
         ecnt[gn-1]  <= ecnt[gn-1] + 1;
      end
   end

   int l2 = 0;
   int n2 = 0;
   int d2 [8];
   int o2 [8];
   int v2 [8];
   always @(negedge clk) begin
      if (pen2) l2 <= cyc;
      if (|bus2.rsp_valid && n2 < 8) begin
         d2[n2] <= cyc - l2;
         o2[n2] <= int'(bus2.rsp_valid);
         v2[n2] <= bus2.rsp_data;
         n2 <= n2 + 1;
      end
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic load(input int i, input int a, input int b,
                       input int c, input int d);
      sv[i][nsamp[i]]   = a;
      sv[i][nsamp[i]+1] = b;
      sv[i][nsamp[i]+2] = c;
      sv[i][nsamp[i]+3] = d;
      nsamp[i] += 4;
   endtask

   int gp = 0;
   int rp = 0;
   int lg = 0;
   int lr = 0;

   task automatic txn(input int idx, input int data);
      int k;
      k = 0;
      while (rn <= rp && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("rsp_timeout", longint'(rn > rp), 1);
      chk("gnt", gid[gp], idx);
      lg = gp;
      gp++;
      chk("rsp_idx", ridx[rp], idx);
      chk("rsp_dat", rdat[rp], data);
      lr = rp;
      rp++;
   endtask

   initial begin
      int k;
      int tgt;
      int rb;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt_id, 0);
      chk("rst_rspv", bus.rsp_valid, 0);
      chk("rst_rspd", bus.rsp_data, 0);
      chk("rst_prst", pool_rst, 0);
      chk("rst_pen", pool_en, 0);
      chk("rst_pip", pool_ip, 0);
      chk("rst_rdy", bus.req_ready, 0);
      rst  = 1'b0;
      rst2 = 1'b0;
      rv2  = 2'b11;

      // Single requester, samples held valid.
      load(0, 4, 8, 12, 16);
      k = 0;
      while (!pool_rst && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t1_prst_seen", pool_rst, 1);
      chk("t1_busy", busy, 1);
      chk("t1_rdy_reset", bus.req_ready, 0);
      @(negedge clk);
      chk("t1_rdy_feed", bus.req_ready, 4'b0001);
      txn(0, 10);
      chk("t1_en_cnt", ecnt[lg], 4);
      chk("t1_en_span", elast[lg] - efirst[lg], 3);
      chk("t1_lat", rcyc[lr] - gcyc[lg], 9);
      chk("t1_wait", rcyc[lr] - elast[lg], 4);
      chk("t1_prst_cnt", gn, 1);

      // All four at once after reset: 0,1,2,3,0.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      load(0, 1, 2, 3, 4);
      load(0, 7, 7, 7, 7);
      load(1, 10, 20, 30, 40);
      load(2, -1, -2, -3, -4);
      load(3, 100, 100, 100, 101);
      txn(0, 2);
      txn(1, 25);
      chk("b2b_1", rcyc[lr] - rcyc[lr-1], 10);
      txn(2, -3);
      chk("b2b_2", rcyc[lr] - rcyc[lr-1], 10);
      txn(3, 100);
      chk("b2b_3", rcyc[lr] - rcyc[lr-1], 10);
      txn(0, 7);
      chk("b2b_4", rcyc[lr] - rcyc[lr-1], 10);

      // req1 stalls 3 cycles after two samples; req3 waits its turn.
      load(1, -8, -8, -8, -4);
      load(3, 5, 5, 5, 5);
      tgt = nsamp[1] - 2;
      k = 0;
      while (ptr[1] != tgt && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("gap_reach", ptr[1], tgt);
      gap[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("gap_gnt", gnt_id, 1);
         chk("gap_rdy", bus.req_ready, 4'b0010);
      end
      gap[1] = 1'b0;
      txn(1, -7);
      chk("gap_en_cnt", ecnt[lg], 4);
      chk("gap_en_span", elast[lg] - efirst[lg], 6);
      txn(3, 5);

      // req3 alone, then 0 and 3 together: pointer wrapped to 0.
      load(3, 1, 1, 1, 1);
      txn(3, 1);
      load(0, 2, 2, 2, 2);
      load(3, 3, 3, 3, 3);
      txn(0, 2);
      txn(3, 3);

      // Reset during req2 WAIT with rr_ptr at 2.
      load(1, 9, 9, 9, 9);
      txn(1, 9);
      load(2, 4, 4, 4, 4);
      tgt = nsamp[2];
      k = 0;
      while (ptr[2] != tgt && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reach", ptr[2], tgt);
      rb = rn;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_rspv", bus.rsp_valid, 0);
      chk("abort_gnt", gnt_id, 0);
      chk("abort_pen", pool_en, 0);
      load(0, 6, 6, 6, 6);
      load(2, 8, 8, 8, 8);
      repeat (4) @(negedge clk);
      chk("abort_no_rsp", rn, rb);
      chk("abort_gnt_log", gid[gp], 2);
      gp++;
      txn(0, 6);
      txn(2, 8);

      repeat (3) @(negedge clk);
      chk("no_extra_rsp", rn, rp);
      chk("gnt_count", gn, gp);
      chk("onehot", viol, 0);

      k = 0;
      while (n2 < 4 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("n2_count", longint'(n2 >= 4), 1);
      for (int i = 0; i < 4; i++) begin
         chk("n2_lat", d2[i], 6);
         chk("n2_owner", o2[i], (i % 2 == 0) ? 1 : 2);
         chk("n2_data", v2[i], 77);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
